// File: rtl/retry_replay_buffer.sv
// rtl/retry_replay_buffer.sv - head-of-section buffer that tags items with slot IDs and replays them on retry
//
// Purpose: accepts upstream items, tags each one with an in-flight slot ID, and
// keeps a copy until the tail of the protected section reports it done.
// A retry report re-issues the stored copy ahead of new input. An item whose
// retries are exhausted is dropped and reported on fail_o.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   data_i/valid_i/ready_o upstream item handshake
//   data_o/id_o/valid_o/ready_i downstream item handshake (data_o tagged with id_o)
//   done_valid_i/done_id_i/done_retry_i completion report from the section tail
//   fail_o/fail_id_o      one-cycle pulse when an item is dropped
//   inflight_o            number of occupied slots
module retry_replay_buffer #(
  parameter int DataWidth  = 8,
  parameter int Depth      = 4,
  parameter int MaxRetries = 3,
  parameter int IDSize     = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [IDSize-1:0]    id_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 done_valid_i,
  input  logic [IDSize-1:0]    done_id_i,
  input  logic                 done_retry_i,
  output logic                 fail_o,
  output logic [IDSize-1:0]    fail_id_o,
  output logic [IDSize:0]      inflight_o
);

  localparam int CntW = IDSize + 1;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_QUEUED = 2'd1,
    SLOT_ISSUED = 2'd2,
    SLOT_REPLAY = 2'd3
  } slot_state_e;

  // Per-slot bookkeeping
  slot_state_e          state_q [Depth];
  slot_state_e          state_d [Depth];
  logic [3:0]           cnt_q   [Depth];
  logic [3:0]           cnt_d   [Depth];
  logic [DataWidth-1:0] mem_q   [Depth];

  // Replay queue of slot IDs
  logic [IDSize-1:0]    rq_mem_q [Depth];
  logic [IDSize-1:0]    rq_rd_q, rq_rd_d;
  logic [IDSize-1:0]    rq_wr_q, rq_wr_d;
  logic [CntW-1:0]      rq_cnt_q, rq_cnt_d;

  // Output register
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;
  logic [IDSize-1:0]    out_id_q, out_id_d;

  logic                 fail_q, fail_d;
  logic [IDSize-1:0]    fail_id_q, fail_id_d;
  logic [CntW-1:0]      inflight_q, inflight_d;

  logic                 any_free;
  logic [IDSize-1:0]    alloc_id;
  logic                 rq_empty;
  logic                 handshake;
  logic                 load_en;
  logic                 accept;
  logic                 done_hit;
  logic                 done_replay;
  logic                 done_fail;
  logic                 done_release;
  logic                 pop;
  logic                 bypass;
  logic                 push;
  logic [IDSize-1:0]    rq_head;

  // Lowest-index FREE slot: scan downward so the lowest match wins.
  always_comb begin
    any_free = 1'b0;
    alloc_id = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) begin
        any_free = 1'b1;
        alloc_id = IDSize'(i);
      end
    end
  end

  assign rq_empty  = (rq_cnt_q == '0);
  assign rq_head   = rq_mem_q[rq_rd_q];
  assign handshake = out_valid_q & ready_i;
  assign load_en   = ~out_valid_q | ready_i;

  // Built from registered state only, so a slot freed this cycle is not offered yet.
  assign ready_o   = ~rst_i & any_free & rq_empty & load_en;
  assign accept    = valid_i & ready_o;

  assign done_hit     = done_valid_i & (state_q[done_id_i] == SLOT_ISSUED);
  assign done_release = done_hit & ~done_retry_i;
  assign done_replay  = done_hit & done_retry_i & (cnt_q[done_id_i] < 4'(MaxRetries));
  assign done_fail    = done_hit & done_retry_i & ~(cnt_q[done_id_i] < 4'(MaxRetries));

  // Queued replays go first. A new input can only be accepted while the queue is
  // empty, so pop and accept never compete. A fresh retry goes straight into the
  // output register when nothing else claims it; otherwise it waits in the queue.
  assign pop    = load_en & ~rq_empty;
  assign bypass = load_en & rq_empty & ~accept & done_replay;
  assign push   = done_replay & ~bypass;

  always_comb begin
    out_valid_d = out_valid_q & ~handshake;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_id_d    = rq_head;
      out_data_d  = mem_q[rq_head];
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_id_d    = alloc_id;
      out_data_d  = data_i;
    end else if (bypass) begin
      out_valid_d = 1'b1;
      out_id_d    = done_id_i;
      out_data_d  = mem_q[done_id_i];
    end
  end

  // Every event below touches a different slot, so the updates never collide.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    if (handshake) begin
      state_d[out_id_q] = SLOT_ISSUED;
    end
    if (done_release || done_fail) begin
      state_d[done_id_i] = SLOT_FREE;
    end
    if (done_replay) begin
      state_d[done_id_i] = bypass ? SLOT_QUEUED : SLOT_REPLAY;
      cnt_d[done_id_i]   = cnt_q[done_id_i] + 4'd1;
    end
    if (pop) begin
      state_d[rq_head] = SLOT_QUEUED;
    end
    if (accept) begin
      state_d[alloc_id] = SLOT_QUEUED;
      cnt_d[alloc_id]   = 4'd0;
    end
  end

  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < Depth; i++) begin
      if (state_d[i] != SLOT_FREE) begin
        inflight_d = inflight_d + CntW'(1);
      end
    end
  end

  always_comb begin
    rq_rd_d  = rq_rd_q;
    rq_wr_d  = rq_wr_q;
    rq_cnt_d = rq_cnt_q;
    if (push) begin
      rq_wr_d = rq_wr_q + IDSize'(1);
    end
    if (pop) begin
      rq_rd_d = rq_rd_q + IDSize'(1);
    end
    if (push && !pop) begin
      rq_cnt_d = rq_cnt_q + CntW'(1);
    end else if (pop && !push) begin
      rq_cnt_d = rq_cnt_q - CntW'(1);
    end
  end

  assign fail_d    = done_fail;
  assign fail_id_d = done_id_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        state_q[i] <= SLOT_FREE;
        cnt_q[i]   <= '0;
      end
      rq_rd_q     <= '0;
      rq_wr_q     <= '0;
      rq_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      fail_q      <= 1'b0;
      fail_id_q   <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rq_rd_q     <= rq_rd_d;
      rq_wr_q     <= rq_wr_d;
      rq_cnt_q    <= rq_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      fail_q      <= fail_d;
      fail_id_q   <= fail_id_d;
      inflight_q  <= inflight_d;
    end
  end

  // Payload and queue storage need no reset; they are only read once written.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[alloc_id] <= data_i;
    end
    if (push && !rst_i) begin
      rq_mem_q[rq_wr_q] <= done_id_i;
    end
  end

  assign valid_o    = out_valid_q;
  assign data_o     = out_data_q;
  assign id_o       = out_id_q;
  assign fail_o     = fail_q;
  assign fail_id_o  = fail_id_q;
  assign inflight_o = inflight_q;

endmodule

// File: tb/tb_retry_replay_buffer.sv
// tb/tb_retry_replay_buffer.sv - self-checking bench for retry_replay_buffer
module tb_retry_replay_buffer;
  localparam int DW  = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  data_i = '0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  logic [DW-1:0]  data_o;
  logic [IDW-1:0] id_o;
  logic           valid_o;
  logic           ready_i = 1'b1;
  logic           done_valid = 1'b0;
  logic [IDW-1:0] done_id = '0;
  logic           done_retry = 1'b0;
  logic           fail_o;
  logic [IDW-1:0] fail_id_o;
  logic [IDW:0]   inflight_o;

  int n_vec  = 0;
  int n_miss = 0;
  int fail_seen = 0;
  logic [IDW-1:0] last_fail_id = '0;
  logic [DW+IDW-1:0] exp_q[$];
  logic [DW+IDW-1:0] exp_e;

  retry_replay_buffer dut (
    .clk_i(clk), .rst_i(rst),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .id_o(id_o), .valid_o(valid_o), .ready_i(ready_i),
    .done_valid_i(done_valid), .done_id_i(done_id), .done_retry_i(done_retry),
    .fail_o(fail_o), .fail_id_o(fail_id_o), .inflight_o(inflight_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every downstream handshake must match the oldest expected item.
  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL sb_unexpected: got data=%h id=%0d, want no output", data_o, id_o);
      end else begin
        exp_e = exp_q.pop_front();
        if ({data_o, id_o} !== exp_e) begin
          n_miss++;
          $display("FAIL sb_item: got data=%h id=%0d, want data=%h id=%0d",
                   data_o, id_o, exp_e[DW+IDW-1:IDW], exp_e[IDW-1:0]);
        end
      end
    end
    if (!rst && fail_o) begin
      fail_seen++;
      last_fail_id = fail_id_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic done(input logic [IDW-1:0] id, input logic retry);
    done_valid = 1'b1; done_id = id; done_retry = retry;
    cyc();
    done_valid = 1'b0; done_retry = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [IDW-1:0] id);
    int n;
    n = 0;
    data_i = d; valid_i = 1'b1;
    #1;
    while (!ready_o && n < 50) begin cyc(); n++; end
    n_vec++;
    if (!ready_o) begin
      n_miss++;
      $display("FAIL send_timeout data=%h: ready_o got 0, want 1", d);
    end else begin
      exp_q.push_back({d, id});
    end
    cyc();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_i = 1'b1;
    cyc(); cyc(); cyc();
    n_vec++; if (ready_o !== 1'b0) begin n_miss++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_vec++; if (fail_o !== 1'b0) begin n_miss++; $display("FAIL reset_fail: got %b want 0", fail_o); end
    n_vec++; if (inflight_o !== 3'd0) begin n_miss++; $display("FAIL reset_inflight: got %0d want 0", inflight_o); end
    rst = 1'b0; #1;
    n_vec++; if (ready_o !== 1'b1) begin n_miss++; $display("FAIL reset_release_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_fill();
    send(8'h11, 2'd0);
    n_vec++; if ({valid_o, data_o, id_o} !== {1'b1, 8'h11, 2'd0}) begin
      n_miss++; $display("FAIL fill_latency: got v=%b d=%h id=%0d want v=1 d=11 id=0", valid_o, data_o, id_o); end
    send(8'h22, 2'd1);
    send(8'h33, 2'd2);
    send(8'h44, 2'd3);
    cyc();
    n_vec++; if (ready_o !== 1'b0) begin n_miss++; $display("FAIL fill_ready: got %b want 0", ready_o); end
    n_vec++; if (inflight_o !== 3'd4) begin n_miss++; $display("FAIL fill_inflight: got %0d want 4", inflight_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_miss++; $display("FAIL fill_drained: got %b want 0", valid_o); end
  endtask

  task automatic test_release();
    done_valid = 1'b1; done_id = 2'd2; done_retry = 1'b0; #1;
    n_vec++; if (ready_o !== 1'b0) begin n_miss++; $display("FAIL release_same_cycle: got %b want 0", ready_o); end
    cyc(); done_valid = 1'b0; #1;
    n_vec++; if (ready_o !== 1'b1) begin n_miss++; $display("FAIL release_next_cycle: got %b want 1", ready_o); end
    send(8'h55, 2'd2);
    cyc();
    n_vec++; if (inflight_o !== 3'd4) begin n_miss++; $display("FAIL release_inflight: got %0d want 4", inflight_o); end
  endtask

  task automatic test_replay_priority();
    data_i = 8'h66; valid_i = 1'b1;
    exp_q.push_back({8'h22, 2'd1});
    done(2'd1, 1'b1);
    ready_i = 1'b0;
    n_vec++; if ({valid_o, data_o, id_o} !== {1'b1, 8'h22, 2'd1}) begin
      n_miss++; $display("FAIL replay_first: got v=%b d=%h id=%0d want v=1 d=22 id=1", valid_o, data_o, id_o); end
    exp_q.push_back({8'h44, 2'd3});
    done(2'd3, 1'b1);
    done(2'd2, 1'b0);
    ready_i = 1'b1; #1;
    n_vec++; if (ready_o !== 1'b0) begin n_miss++; $display("FAIL replay_blocks_input: got %b want 0", ready_o); end
    n_vec++; if (inflight_o !== 3'd3) begin n_miss++; $display("FAIL replay_inflight: got %0d want 3", inflight_o); end
    cyc();
    n_vec++; if ({valid_o, data_o, id_o} !== {1'b1, 8'h44, 2'd3}) begin
      n_miss++; $display("FAIL replay_queued: got v=%b d=%h id=%0d want v=1 d=44 id=3", valid_o, data_o, id_o); end
    send(8'h66, 2'd2);
    cyc();
  endtask

  task automatic test_max_retries();
    int f0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({8'h11, 2'd0});
      done(2'd0, 1'b1);
      n_vec++; if ({valid_o, data_o, id_o, fail_o} !== {1'b1, 8'h11, 2'd0, 1'b0}) begin
        n_miss++; $display("FAIL retry_%0d: got v=%b d=%h id=%0d f=%b want v=1 d=11 id=0 f=0", k, valid_o, data_o, id_o, fail_o); end
      cyc();
    end
    f0 = fail_seen;
    done(2'd0, 1'b1);
    n_vec++; if ({fail_o, fail_id_o, valid_o} !== {1'b1, 2'd0, 1'b0}) begin
      n_miss++; $display("FAIL retry_exhausted: got f=%b fid=%0d v=%b want f=1 fid=0 v=0", fail_o, fail_id_o, valid_o); end
    cyc();
    n_vec++; if (fail_o !== 1'b0) begin n_miss++; $display("FAIL fail_pulse_width: got %b want 0", fail_o); end
    n_vec++; if (fail_seen !== f0 + 1) begin n_miss++; $display("FAIL fail_count: got %0d want %0d", fail_seen, f0 + 1); end
    n_vec++; if (inflight_o !== 3'd3) begin n_miss++; $display("FAIL fail_inflight: got %0d want 3", inflight_o); end
    n_vec++; if (ready_o !== 1'b1) begin n_miss++; $display("FAIL fail_slot_free: got %b want 1", ready_o); end
  endtask

  task automatic test_hold();
    done(2'd3, 1'b0);
    ready_i = 1'b0;
    send(8'h77, 2'd0);
    for (int i = 0; i < 5; i++) begin
      done_valid = (i == 1) || (i == 2);
      done_id    = (i == 1) ? 2'd0 : 2'd3;
      done_retry = 1'b1;
      n_vec++; if ({valid_o, data_o, id_o, fail_o} !== {1'b1, 8'h77, 2'd0, 1'b0}) begin
        n_miss++; $display("FAIL hold_%0d: got v=%b d=%h id=%0d f=%b want v=1 d=77 id=0 f=0", i, valid_o, data_o, id_o, fail_o); end
      cyc();
    end
    done_valid = 1'b0; done_retry = 1'b0; #1;
    n_vec++; if (ready_o !== 1'b0) begin n_miss++; $display("FAIL hold_ready: got %b want 0", ready_o); end
    n_vec++; if (inflight_o !== 3'd3) begin n_miss++; $display("FAIL hold_inflight: got %0d want 3", inflight_o); end
    ready_i = 1'b1; #1;
    n_vec++; if (ready_o !== 1'b1) begin n_miss++; $display("FAIL hold_release_ready: got %b want 1", ready_o); end
    send(8'h88, 2'd3);
    cyc();
  endtask

  task automatic test_reset_midflight();
    int f0;
    done(2'd1, 1'b0);
    n_vec++; if (inflight_o !== 3'd3) begin n_miss++; $display("FAIL midrst_pre_inflight: got %0d want 3", inflight_o); end
    n_vec++; if (exp_q.size() !== 0) begin n_miss++; $display("FAIL midrst_pre_sb: got %0d pending want 0", exp_q.size()); end
    f0 = fail_seen;
    rst = 1'b1; #1;
    n_vec++; if (ready_o !== 1'b0) begin n_miss++; $display("FAIL midrst_ready: got %b want 0", ready_o); end
    cyc();
    rst = 1'b0; #1;
    n_vec++; if ({valid_o, fail_o, inflight_o} !== {1'b0, 1'b0, 3'd0}) begin
      n_miss++; $display("FAIL midrst_state: got v=%b f=%b inflight=%0d want v=0 f=0 inflight=0", valid_o, fail_o, inflight_o); end
    send(8'h99, 2'd0);
    n_vec++; if ({valid_o, data_o, id_o} !== {1'b1, 8'h99, 2'd0}) begin
      n_miss++; $display("FAIL midrst_first_id: got v=%b d=%h id=%0d want v=1 d=99 id=0", valid_o, data_o, id_o); end
    cyc();
    done(2'd2, 1'b1);
    cyc();
    n_vec++; if ({valid_o, inflight_o} !== {1'b0, 3'd1}) begin
      n_miss++; $display("FAIL midrst_stale_done: got v=%b inflight=%0d want v=0 inflight=1", valid_o, inflight_o); end
    n_vec++; if (fail_seen !== f0) begin n_miss++; $display("FAIL midrst_no_fail: got %0d pulses want %0d", fail_seen, f0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release();
    test_replay_priority();
    test_max_retries();
    test_hold();
    test_reset_midflight();
    cyc(); cyc();
    n_vec++; if (exp_q.size() !== 0) begin n_miss++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size()); end
    n_vec++; if (last_fail_id !== 2'd0) begin n_miss++; $display("FAIL last_fail_id: got %0d want 0", last_fail_id); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
